// File: rtl/kb_ascii_fifo.sv
// Keyboard make-code to ASCII translator feeding a show-ahead FIFO.
// Translation happens on the write side, so the FIFO stores plain 8-bit ASCII.
module kb_ascii_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scan_code_i,
    input  logic          scan_code_ready_i,
    input  logic          letter_case_i,
    input  logic          rd_en_i,
    input  logic          ovf_clr_i,
    output logic [7:0]    rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [7:0]    ascii;
    logic          mapped;
    logic          is_letter;
    logic          push, pop, drop;

    // Letters decode to lower case; upper case is derived by clearing bit 5.
    always_comb begin
        ascii     = 8'h00;
        mapped    = 1'b1;
        is_letter = 1'b1;
        case (scan_code_i)
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h45: begin ascii = 8'h30; is_letter = 1'b0; end
            8'h16: begin ascii = 8'h31; is_letter = 1'b0; end
            8'h1E: begin ascii = 8'h32; is_letter = 1'b0; end
            8'h26: begin ascii = 8'h33; is_letter = 1'b0; end
            8'h25: begin ascii = 8'h34; is_letter = 1'b0; end
            8'h2E: begin ascii = 8'h35; is_letter = 1'b0; end
            8'h36: begin ascii = 8'h36; is_letter = 1'b0; end
            8'h3D: begin ascii = 8'h37; is_letter = 1'b0; end
            8'h3E: begin ascii = 8'h38; is_letter = 1'b0; end
            8'h46: begin ascii = 8'h39; is_letter = 1'b0; end
            8'h29: begin ascii = 8'h20; is_letter = 1'b0; end
            8'h5A: begin ascii = 8'h0D; is_letter = 1'b0; end
            8'h66: begin ascii = 8'h08; is_letter = 1'b0; end
            default: begin
                mapped    = 1'b0;
                is_letter = 1'b0;
            end
        endcase
        if (is_letter && letter_case_i) begin
            ascii[5] = 1'b0;
        end
    end

    assign empty_o = (count_q == '0);
    // Occupancy never exceeds Depth, so the MSB alone marks full.
    assign full_o  = count_q[AW];

    assign pop  = rd_en_i && !empty_o;
    assign push = scan_code_ready_i && mapped && (!full_o || pop);
    assign drop = scan_code_ready_i && mapped && full_o && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ascii;
        end
    end

    assign rd_data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_kb_ascii_fifo.sv
// Directed bench for kb_ascii_fifo: translation, ordering, full/overflow and reset.
module tb_kb_ascii_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       letter_case;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] letter_codes [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    logic [7:0] digit_codes  [8] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

    kb_ascii_fifo #(.AW(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .scan_code_i       (scan_code),
        .scan_code_ready_i (scan_code_ready),
        .letter_case_i     (letter_case),
        .rd_en_i           (rd_en),
        .ovf_clr_i         (ovf_clr),
        .rd_data_o         (rd_data),
        .empty_o           (empty),
        .full_o            (full),
        .count_o           (count),
        .overflow_o        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] code, input logic upper);
        scan_code       = code;
        letter_case     = upper;
        scan_code_ready = 1'b1;
        tick();
        scan_code_ready = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] c, input logic e,
                             input logic f, input logic o);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        reset = 1'b1; scan_code = 8'h00; scan_code_ready = 1'b0;
        letter_case = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        #1;
        chk_state("reset", 4'd0, 1'b1, 1'b0, 1'b0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Lower then upper 'a'
        push(8'h1C, 1'b0);
        chk("a_lower_head", 32'(rd_data), 32'h61);
        chk_state("a_one", 4'd1, 1'b0, 1'b0, 1'b0);
        push(8'h1C, 1'b1);
        chk("a_two_head", 32'(rd_data), 32'h61);
        chk("a_two_count", 32'(count), 32'd2);
        pop();
        chk("a_upper_head", 32'(rd_data), 32'h41);
        pop();
        chk_state("a_drained", 4'd0, 1'b1, 1'b0, 1'b0);

        // Digits and controls ignore letter_case
        push(8'h16, 1'b1); push(8'h29, 1'b1); push(8'h5A, 1'b1); push(8'h66, 1'b1);
        chk("ctl_count", 32'(count), 32'd4);
        chk("ctl_1", 32'(rd_data), 32'h31); pop();
        chk("ctl_sp", 32'(rd_data), 32'h20); pop();
        chk("ctl_cr", 32'(rd_data), 32'h0D); pop();
        chk("ctl_bs", 32'(rd_data), 32'h08); pop();
        chk("ctl_empty", 32'(empty), 32'd1);

        // Unmapped codes are discarded silently
        push(8'h76, 1'b0); push(8'hE0, 1'b1);
        chk_state("unmapped", 4'd0, 1'b1, 1'b0, 1'b0);

        // Pop while empty is ignored; pop + write at empty only writes
        pop();
        chk("underflow_count", 32'(count), 32'd0);
        rd_en = 1'b1;
        push(8'h4D, 1'b1);
        rd_en = 1'b0;
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_head", 32'(rd_data), 32'h50);
        pop();
        chk("empty_rw_drain", 32'(empty), 32'd1);

        // Fill to full, then one dropped write sets overflow
        for (int i = 0; i < 8; i++) push(letter_codes[i], 1'b0);
        chk_state("fill8", 4'd8, 1'b0, 1'b1, 1'b0);
        push(8'h43, 1'b0);
        chk_state("drop9", 4'd8, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_pop%0d", i), 32'(rd_data), 32'h61 + 32'(i));
            pop();
        end
        chk_state("fill_drained", 4'd0, 1'b1, 1'b0, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // At full, simultaneous write and pop keeps count and does not overflow
        for (int i = 0; i < 8; i++) push(digit_codes[i], 1'b0);
        chk("digits_full", 32'(full), 32'd1);
        rd_en = 1'b1;
        push(8'h1A, 1'b0);
        rd_en = 1'b0;
        chk_state("full_rw", 4'd8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("wrap_pop%0d", i), 32'(rd_data), 32'h31 + 32'(i));
            pop();
        end
        chk("wrap_last", 32'(rd_data), 32'h7A);
        pop();
        chk("wrap_empty", 32'(empty), 32'd1);

        // Overflow set wins over a same-cycle clear
        for (int i = 0; i < 8; i++) push(digit_codes[i], 1'b0);
        ovf_clr = 1'b1;
        push(8'h45, 1'b0);
        ovf_clr = 1'b0;
        chk("set_wins", 32'(overflow), 32'd1);
        push(8'h76, 1'b0);
        chk("unmapped_full_ovf", 32'(overflow), 32'd1);
        chk("unmapped_full_count", 32'(count), 32'd8);

        // Reset mid-stream, with a strobe coincident with reset
        reset = 1'b1; #1; reset = 1'b0; tick();
        push(8'h1C, 1'b0); push(8'h32, 1'b0); push(8'h21, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd3);
        reset = 1'b1;
        #1;
        chk_state("mid_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        chk("mid_reset_rd", 32'(rd_data), 32'h00);
        push(8'h24, 1'b0);
        chk("reset_strobe_ignored", 32'(count), 32'd0);
        reset = 1'b0;
        tick();
        push(8'h45, 1'b0);
        chk("post_reset_head", 32'(rd_data), 32'h30);
        chk("post_reset_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
